// File: rtl/usb_crc_pkg.sv
// Shared types, polynomials and FSM encodings for the USB CRC serializer.
// Also provides the one-bit serial CRC step used by the LFSR.
package usb_crc_pkg;

  typedef enum logic {
    CRC5  = 1'b0,
    CRC16 = 1'b1
  } crc_mode_t;

  localparam logic [4:0]  CRC5_POLY     = 5'b00101;
  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam int          CRC5_W        = 5;
  localparam int          CRC16_W       = 16;
  localparam int          TOKEN_FIELD_W = 11;

  // Remainder a receiver sees after running the CRC over field plus sent CRC
  localparam logic [4:0]  CRC5_RES  = 5'b01100;
  localparam logic [15:0] CRC16_RES = 16'h800D;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_CRC  = 2'd2;

  // MSB-feedback serial step; in CRC5 mode bits [15:5] are carried unchanged
  function automatic logic [15:0] crc_next(input logic [15:0] crc,
                                           input logic        din,
                                           input crc_mode_t   mode);
    logic        fb;
    logic [15:0] r;
    if (mode == CRC16) begin
      fb = din ^ crc[15];
      r  = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end else begin
      fb = din ^ crc[4];
      r  = {crc[15:5], crc[3:0], 1'b0} ^ {11'h000, (fb ? CRC5_POLY : 5'h00)};
    end
    return r;
  endfunction

endpackage

// File: rtl/usb_crc_lfsr.sv
// Serial CRC register, 16 bits wide; CRC5 mode works on bits [4:0] only.
module usb_crc_lfsr
  import usb_crc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        step,
  input  logic        data_bit,
  input  crc_mode_t   mode,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // Next-state: seed to all-ones at the selected width, or advance one bit
  always_comb begin
    crc_d = crc_q;
    if (init) begin
      if (mode == CRC16) begin
        crc_d = 16'hFFFF;
      end else begin
        crc_d = {crc_q[15:5], 5'h1F};
      end
    end else if (step) begin
      crc_d = crc_next(crc_q, data_bit, mode);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= 16'hFFFF;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_crc_serializer.sv
// Loads a token or data field, streams it LSB-first, then the inverted CRC
// MSB-first, under valid/ready flow control on the serial side.
module usb_crc_serializer
  import usb_crc_pkg::*;
#(
  parameter int MAX_FIELD_W = 64,
  parameter int LEN_W       = $clog2(MAX_FIELD_W + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   crc_mode,
  input  logic [MAX_FIELD_W-1:0] field,
  input  logic [LEN_W-1:0]       field_len,
  output logic                   out_bit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   err_len
);

  localparam int IDX_W = $clog2(MAX_FIELD_W);

  logic [1:0]             state_q, state_d;
  logic [LEN_W-1:0]       idx_q, idx_d;
  logic [LEN_W-1:0]       len_q;
  logic [MAX_FIELD_W-1:0] field_q;
  crc_mode_t              mode_q;
  logic                   err_q;

  logic                   load_s;
  logic                   len_ok_s;
  logic                   lfsr_step_s;
  crc_mode_t              lfsr_mode_s;
  logic [15:0]            crc_s;
  logic [15:0]            crc_msb_s;
  logic [3:0]             crc_idx_s;
  logic [IDX_W-1:0]       field_idx_s;
  logic                   data_bit_s;
  logic                   crc_bit_s;
  logic [LEN_W-1:0]       last_crc_idx_s;

  assign load_s = in_valid & (state_q == ST_IDLE);

  // Length legality of the incoming load
  always_comb begin
    if (crc_mode_t'(crc_mode) == CRC16) begin
      len_ok_s = (field_len[2:0] == 3'd0) && (field_len <= LEN_W'(MAX_FIELD_W));
    end else begin
      len_ok_s = (field_len == LEN_W'(TOKEN_FIELD_W));
    end
  end

  // The seed width must follow the incoming mode, not the previous packet's
  assign lfsr_mode_s = load_s ? crc_mode_t'(crc_mode) : mode_q;

  usb_crc_lfsr u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .init     (load_s),
    .step     (lfsr_step_s),
    .data_bit (data_bit_s),
    .mode     (lfsr_mode_s),
    .crc      (crc_s)
  );

  // Left-align the active CRC so bit 15 is always its MSB
  assign crc_msb_s      = (mode_q == CRC16) ? crc_s : {crc_s[4:0], 11'h000};
  assign crc_idx_s      = 4'd15 - idx_q[3:0];
  assign crc_bit_s      = crc_msb_s[crc_idx_s];
  assign field_idx_s    = idx_q[IDX_W-1:0];
  assign data_bit_s     = field_q[field_idx_s];
  assign last_crc_idx_s = (mode_q == CRC16) ? LEN_W'(CRC16_W - 1) : LEN_W'(CRC5_W - 1);

  // Packet sequencing: IDLE -> DATA (skipped for empty payloads) -> CRC -> IDLE
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lfsr_step_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_s && len_ok_s) begin
          idx_d   = {LEN_W{1'b0}};
          state_d = (field_len != {LEN_W{1'b0}}) ? ST_DATA : ST_CRC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (out_ready) begin
          lfsr_step_s = 1'b1;
          if (idx_q == len_q - LEN_W'(1)) begin
            state_d = ST_CRC;
            idx_d   = {LEN_W{1'b0}};
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CRC: begin
        if (out_ready) begin
          if (idx_q == last_crc_idx_s) begin
            state_d = ST_IDLE;
            idx_d   = {LEN_W{1'b0}};
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end else begin
          state_d = ST_CRC;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {LEN_W{1'b0}};
      end
    endcase
  end

  // Control state, load capture and the reject pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= {LEN_W{1'b0}};
      len_q   <= {LEN_W{1'b0}};
      field_q <= {MAX_FIELD_W{1'b0}};
      mode_q  <= CRC5;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= load_s & ~len_ok_s;
      if (load_s) begin
        field_q <= field;
        len_q   <= field_len;
        mode_q  <= crc_mode_t'(crc_mode);
      end else begin
        field_q <= field_q;
        len_q   <= len_q;
        mode_q  <= mode_q;
      end
    end
  end

  // Serial bit selection
  always_comb begin
    case (state_q)
      ST_DATA: out_bit = data_bit_s;
      ST_CRC:  out_bit = ~crc_bit_s;
      default: out_bit = 1'b0;
    endcase
  end

  assign out_valid = (state_q != ST_IDLE);
  assign out_last  = (state_q == ST_CRC) && (idx_q == last_crc_idx_s);
  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = ~in_ready;
  assign err_len   = err_q;

endmodule

// File: tb/tb_usb_crc_serializer.sv
// Directed and randomized bench for usb_crc_serializer; expected streams come
// from polynomial long division over the whole message.
module tb_usb_crc_serializer;
  import usb_crc_pkg::*;

  localparam int MAXW = 64;
  localparam int LW   = $clog2(MAXW + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic            crc_mode;
  logic [MAXW-1:0] field;
  logic [LW-1:0]   field_len;
  logic            out_bit;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            busy;
  logic            err_len;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  usb_crc_serializer #(.MAX_FIELD_W(MAXW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .crc_mode  (crc_mode),
    .field     (field),
    .field_len (field_len),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .err_len   (err_len)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Remainder of (M(x)*x^w + ones*x^n) mod G(x); bit 0 of msg is highest degree
  function automatic logic [15:0] crc_div(input logic [159:0] msg, input int n,
                                          input int w, input logic [16:0] gen);
    bit          a [0:191];
    logic [15:0] r;
    for (int i = 0; i < 192; i++) a[i] = 1'b0;
    for (int i = 0; i < n; i++) a[i] = msg[i];
    for (int i = 0; i < w; i++) a[i] = a[i] ^ 1'b1;
    for (int i = 0; i < n; i++)
      if (a[i])
        for (int j = 0; j <= w; j++) a[i+j] = a[i+j] ^ gen[w-j];
    r = 16'h0000;
    for (int j = 0; j < w; j++) r[w-1-j] = a[n+j];
    return r;
  endfunction

  // Load one packet and consume it; abort_at >= 0 stops after that many bits
  task automatic run_pkt(input logic m, input logic [63:0] f, input int len,
                         input bit rnd, input int abort_at);
    int           w, total, k, cyc;
    logic [16:0]  gen;
    logic [159:0] ev, sv;
    logic [15:0]  rem;
    bit           have_prev;
    logic         pb, pl;
    w   = m ? 16 : 5;
    gen = m ? 17'h18005 : 17'h00025;
    ev  = '0;
    sv  = '0;
    for (int i = 0; i < len; i++) ev[i] = f[i];
    rem = crc_div({96'd0, f}, len, w, gen);
    for (int j = 0; j < w; j++) ev[len+j] = ~rem[w-1-j];
    total = len + w;

    in_valid  = 1'b1;
    crc_mode  = m;
    field     = f;
    field_len = LW'(len);
    @(negedge clk);
    in_valid  = 1'b0;
    field     = ~f;
    field_len = '0;
    chk("first_valid", out_valid, 1);
    chk("busy_high", busy, 1);
    chk("in_ready_low", in_ready, 0);

    k = 0; cyc = 0; have_prev = 1'b0; pb = 1'b0; pl = 1'b0;
    while (k < total && cyc < 400 && k != abort_at) begin
      if (have_prev) begin
        chk("stall_bit", out_bit, pb);
        chk("stall_last", out_last, pl);
      end
      chk("valid", out_valid, 1);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready) begin
        chk($sformatf("bit%0d", k), out_bit, ev[k]);
        chk($sformatf("last%0d", k), out_last, (k == total - 1));
        sv[k] = out_bit;
        k++;
        have_prev = 1'b0;
      end else begin
        have_prev = 1'b1;
        pb = out_bit;
        pl = out_last;
      end
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    if (k == abort_at) return;
    chk("cycle_budget", (cyc < 400), 1);
    chk("in_ready_after", in_ready, 1);
    chk("valid_after", out_valid, 0);
    if (!rnd) chk("packet_cycles", cyc, total);
    chk("residual", crc_div(sv, total, w, gen), m ? 16'h800D : 16'h000C);
  endtask

  task automatic reject(input logic m, input int len);
    in_valid  = 1'b1;
    crc_mode  = m;
    field     = {$urandom, $urandom};
    field_len = LW'(len);
    @(negedge clk);
    in_valid = 1'b0;
    chk($sformatf("err_pulse_len%0d", len), err_len, 1);
    chk("rej_valid", out_valid, 0);
    chk("rej_in_ready", in_ready, 1);
    @(negedge clk);
    chk("err_clear", err_len, 0);
    chk("rej_valid2", out_valid, 0);
    chk("rej_in_ready2", in_ready, 1);
  endtask

  initial begin
    logic m;
    int   len;
    rst = 1'b1; in_valid = 1'b0; crc_mode = 1'b0; field = '0; field_len = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bit", out_bit, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err_len", err_len, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    run_pkt(1'b0, 64'h0, 11, 1'b0, -1);
    run_pkt(1'b0, 64'h715, 11, 1'b0, -1);
    run_pkt(1'b1, 64'h0, 0, 1'b0, -1);
    run_pkt(1'b1, 64'h03020100, 32, 1'b1, -1);
    run_pkt(1'b1, {$urandom, $urandom}, 64, 1'b0, -1);

    reject(1'b1, 12);
    reject(1'b0, 10);
    reject(1'b1, MAXW + 8);

    for (int t = 0; t < 6; t++) begin
      m   = 1'($urandom_range(0, 1));
      len = m ? 8 * int'($urandom_range(0, 8)) : 11;
      run_pkt(m, {$urandom, $urandom}, len, 1'b1, -1);
    end

    run_pkt(1'b1, {$urandom, $urandom}, 32, 1'b0, 5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_last", out_last, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_pkt(1'b0, {$urandom, $urandom}, 11, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
